// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, debug-loaded instruction memory and IF/ID register.
// Fetch freezes once a HALT word is captured; only reset leaves the HALTED state.
module if_stage #(
    parameter int                NB_REG       = 32,
    parameter int                NB_IMEM_ADDR = 8,
    parameter logic [NB_REG-1:0] HALT_INST    = 32'hFFFFFFFF
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_dunit_clk_en,
    input  logic                    i_stall,
    input  logic                    i_flush,
    input  logic                    i_PCSrc,
    input  logic [NB_REG-1:0]       i_pc_jsel,
    input  logic                    i_imem_wr_en,
    input  logic [NB_IMEM_ADDR-1:0] i_imem_wr_addr,
    input  logic [NB_REG-1:0]       i_imem_wr_data,
    output logic [NB_REG-1:0]       o_inst_to_ID,
    output logic [NB_REG-1:0]       o_pcplus4,
    output logic [NB_REG-1:0]       o_pc,
    output logic                    o_halt
);

    localparam int DEPTH = 1 << NB_IMEM_ADDR;

    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

    logic [NB_REG-1:0] imem [DEPTH];

    state_t            state_reg, state_next;
    logic [NB_REG-1:0] pc_reg, pc_next;
    logic [NB_REG-1:0] inst_reg, inst_next;
    logic [NB_REG-1:0] pcplus4_reg, pcplus4_next;

    logic [NB_REG-1:0] fetch_word;
    logic [NB_REG-1:0] pc_plus4;
    logic [NB_REG-1:0] jsel_aligned;
    logic              halt_detect;

    // Debug-unit load port; deliberately not tied to reset or the step enable.
    always_ff @(posedge i_clk) begin
        if (i_imem_wr_en)
            imem[i_imem_wr_addr] <= i_imem_wr_data;
    end

    assign fetch_word   = imem[pc_reg[NB_IMEM_ADDR+1:2]];
    assign pc_plus4     = pc_reg + NB_REG'(4);
    assign jsel_aligned = i_pc_jsel & ~NB_REG'(3);
    assign halt_detect  = (state_reg == RUN) && (fetch_word == HALT_INST)
                          && !i_stall && !i_flush;

    // State register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)
            state_reg <= RUN;
        else if (i_dunit_clk_en)
            state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (halt_detect) state_next = HALTED;
            HALTED:  state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    // Output logic
    always_comb begin
        o_halt = (state_reg == HALTED);
    end

    // PC and IF/ID next values; stall outranks both redirect and flush.
    always_comb begin
        pc_next      = pc_reg;
        inst_next    = inst_reg;
        pcplus4_next = pcplus4_reg;

        if (state_reg == RUN && !i_stall && !halt_detect) begin
            if (i_PCSrc)
                pc_next = jsel_aligned;
            else
                pc_next = pc_plus4;
        end

        if (!i_stall) begin
            pcplus4_next = pc_plus4;
            if (i_flush || state_reg == HALTED)
                inst_next = '0;
            else
                inst_next = fetch_word;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pc_reg      <= '0;
            inst_reg    <= '0;
            pcplus4_reg <= '0;
        end else if (i_dunit_clk_en) begin
            pc_reg      <= pc_next;
            inst_reg    <= inst_next;
            pcplus4_reg <= pcplus4_next;
        end
    end

    assign o_pc         = pc_reg;
    assign o_inst_to_ID = inst_reg;
    assign o_pcplus4    = pcplus4_reg;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: program load, redirect, stall, flush, step enable, wrap and halt.
module tb_if_stage;

    logic        i_clk;
    logic        i_reset;
    logic        i_dunit_clk_en;
    logic        i_stall;
    logic        i_flush;
    logic        i_PCSrc;
    logic [31:0] i_pc_jsel;
    logic        i_imem_wr_en;
    logic [7:0]  i_imem_wr_addr;
    logic [31:0] i_imem_wr_data;
    logic [31:0] o_inst_to_ID;
    logic [31:0] o_pcplus4;
    logic [31:0] o_pc;
    logic        o_halt;

    int vectors_reg = 0;
    int errors_reg  = 0;

    if_stage dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_dunit_clk_en (i_dunit_clk_en),
        .i_stall        (i_stall),
        .i_flush        (i_flush),
        .i_PCSrc        (i_PCSrc),
        .i_pc_jsel      (i_pc_jsel),
        .i_imem_wr_en   (i_imem_wr_en),
        .i_imem_wr_addr (i_imem_wr_addr),
        .i_imem_wr_data (i_imem_wr_data),
        .o_inst_to_ID   (o_inst_to_ID),
        .o_pcplus4      (o_pcplus4),
        .o_pc           (o_pc),
        .o_halt         (o_halt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors_reg++;
        if (got !== exp) begin
            errors_reg++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                             input logic [31:0] p4, input logic halt);
        check_vec({tag, ".pc"},   o_pc,          pc);
        check_vec({tag, ".inst"}, o_inst_to_ID,  inst);
        check_vec({tag, ".p4"},   o_pcplus4,     p4);
        check_vec({tag, ".halt"}, {31'd0, o_halt}, {31'd0, halt});
        $display("[%0t] %s pc=%h inst=%h p4=%h halt=%0b", $time, tag, o_pc, o_inst_to_ID, o_pcplus4, o_halt);
    endtask

    // One clock edge; inputs change and outputs are sampled on the falling edge.
    task automatic step;
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic mem_write(input logic [7:0] addr, input logic [31:0] data);
        i_imem_wr_en   = 1'b1;
        i_imem_wr_addr = addr;
        i_imem_wr_data = data;
        step();
        i_imem_wr_en   = 1'b0;
    endtask

    initial begin
        i_reset        = 1'b1;
        i_dunit_clk_en = 1'b1;
        i_stall        = 1'b0;
        i_flush        = 1'b0;
        i_PCSrc        = 1'b0;
        i_pc_jsel      = '0;
        i_imem_wr_en   = 1'b0;
        i_imem_wr_addr = '0;
        i_imem_wr_data = '0;
        #2 i_reset = 1'b0;
        @(negedge i_clk);

        // Program 1 loaded under reset
        mem_write(8'd0, 32'h20010005);
        mem_write(8'd1, 32'h20020007);
        mem_write(8'd2, 32'h00221820);
        mem_write(8'd3, 32'hFFFFFFFF);
        check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        i_reset = 1'b1;

        step(); check_all("p1_f0", 32'h4, 32'h20010005, 32'h4, 1'b0);
        step(); check_all("p1_f1", 32'h8, 32'h20020007, 32'h8, 1'b0);
        step(); check_all("p1_f2", 32'hC, 32'h00221820, 32'hC, 1'b0);
        step(); check_all("p1_halt", 32'hC, 32'hFFFFFFFF, 32'h10, 1'b1);
        step(); check_all("p1_halted", 32'hC, 32'h0, 32'h10, 1'b1);
        step(); check_all("p1_halted2", 32'hC, 32'h0, 32'h10, 1'b1);

        // Async reset while halted, then rerun from 0 with memory intact
        #1 i_reset = 1'b0;
        #1 check_all("halt_reset", 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge i_clk);
        i_reset = 1'b1;
        step(); check_all("rerun_f0", 32'h4, 32'h20010005, 32'h4, 1'b0);

        // Program 2 loaded under reset
        i_reset = 1'b0;
        for (int k = 0; k < 16; k++)
            mem_write(8'(k), 32'h10000000 + 32'(k));
        mem_write(8'd255, 32'h12345678);
        i_reset = 1'b1;

        step(); check_all("p2_f0", 32'h4, 32'h10000000, 32'h4, 1'b0);

        i_PCSrc = 1'b1; i_pc_jsel = 32'h22;
        step(); check_all("redir", 32'h20, 32'h10000001, 32'h8, 1'b0);
        i_PCSrc = 1'b0;
        step(); check_all("redir_fetch", 32'h24, 32'h10000008, 32'h24, 1'b0);

        i_stall = 1'b1; i_PCSrc = 1'b1; i_pc_jsel = 32'h40; i_flush = 1'b1;
        step(); check_all("stall1", 32'h24, 32'h10000008, 32'h24, 1'b0);
        i_flush = 1'b0;
        step(); check_all("stall2", 32'h24, 32'h10000008, 32'h24, 1'b0);
        i_stall = 1'b0; i_PCSrc = 1'b0;
        step(); check_all("unstall", 32'h28, 32'h10000009, 32'h28, 1'b0);

        i_flush = 1'b1;
        step(); check_all("flush", 32'h2C, 32'h0, 32'h2C, 1'b0);
        i_flush = 1'b0;
        step(); check_all("post_flush", 32'h30, 32'h1000000B, 32'h30, 1'b0);

        // Step enable off while the debug unit rewrites the word at PC
        i_dunit_clk_en = 1'b0;
        i_imem_wr_en = 1'b1; i_imem_wr_addr = 8'd12; i_imem_wr_data = 32'hAAAA5555;
        i_PCSrc = 1'b1; i_pc_jsel = 32'h80;
        for (int c = 0; c < 3; c++) begin
            step(); check_all($sformatf("clk_en_off%0d", c), 32'h30, 32'h1000000B, 32'h30, 1'b0);
        end
        i_imem_wr_en = 1'b0; i_PCSrc = 1'b0;
        i_dunit_clk_en = 1'b1;
        step(); check_all("clk_en_on", 32'h34, 32'hAAAA5555, 32'h34, 1'b0);

        // Unaligned redirect near the top of the address space, then 32-bit wrap
        i_PCSrc = 1'b1; i_pc_jsel = 32'hFFFFFFFE;
        step(); check_all("redir_top", 32'hFFFFFFFC, 32'h1000000D, 32'h38, 1'b0);
        i_PCSrc = 1'b0;
        i_imem_wr_en = 1'b1; i_imem_wr_addr = 8'd1; i_imem_wr_data = 32'hFFFFFFFF;
        step(); check_all("wrap", 32'h0, 32'h12345678, 32'h0, 1'b0);
        i_imem_wr_en = 1'b0;
        step(); check_all("wrap_f0", 32'h4, 32'h10000000, 32'h4, 1'b0);

        // Halt fetched alongside a redirect still halts
        i_PCSrc = 1'b1; i_pc_jsel = 32'h80;
        step(); check_all("halt_vs_redir", 32'h4, 32'hFFFFFFFF, 32'h8, 1'b1);
        step(); check_all("halted_redir", 32'h4, 32'h0, 32'h8, 1'b1);
        i_PCSrc = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors_reg, errors_reg);
        $finish;
    end

endmodule
